// File: rtl/cpu_mem_sequencer.sv
// Multi-cycle fetch / load-store sequencer sharing one valid/ready memory port,
// with a response watchdog, terminal HALT/ERR states and a retired-instruction counter.
module cpu_mem_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [2:0]  FETCH_OP       = 3'b010,
   parameter logic [31:0] RESET_INST     = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ifu_pc,
   output logic [31:0] inst,
   input  logic        lsu_req,
   input  logic        lsu_wen,
   input  logic [2:0]  lsu_op,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   output logic [31:0] lsu_rdata,
   input  logic        halt_req,
   output logic        commit,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_wen,
   output logic [2:0]  mem_req_op,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        halted,
   output logic        bus_err,
   output logic [31:0] instret
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      IDLE, IF_REQ, IF_WAIT, EX, LS_REQ, LS_WAIT, WB, HALT, ERR
   } state_t;

   state_t          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [31:0]     inst_q, inst_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     instret_q, instret_d;
   logic [31:0]     ls_addr_q, ls_addr_d;
   logic [31:0]     ls_wdata_q, ls_wdata_d;
   logic            ls_wen_q, ls_wen_d;
   logic [2:0]      ls_op_q, ls_op_d;
   logic            retire;
   logic            wd_active;

   // Retire decision depends on decode of the latched instruction, so it is taken in EX/WB itself
   assign retire    = ((state_q == EX) && !lsu_req) || (state_q == WB);
   assign wd_active = (state_q == IF_REQ) || (state_q == IF_WAIT) ||
                      (state_q == LS_REQ) || (state_q == LS_WAIT);

   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      inst_d     = inst_q;
      rdata_d    = rdata_q;
      instret_d  = instret_q;
      ls_addr_d  = ls_addr_q;
      ls_wdata_d = ls_wdata_q;
      ls_wen_d   = ls_wen_q;
      ls_op_d    = ls_op_q;

      case (state_q)
         IDLE:    state_d = IF_REQ;
         IF_REQ:  if (mem_req_ready) state_d = IF_WAIT;
         IF_WAIT: begin
            if (mem_resp_valid) begin
               inst_d  = mem_resp_data;
               state_d = EX;
            end
         end
         EX: begin
            if (lsu_req) begin
               // Operands are captured so the request cannot drift while ready is low
               ls_addr_d  = lsu_addr;
               ls_wdata_d = lsu_wdata;
               ls_wen_d   = lsu_wen;
               ls_op_d    = lsu_op;
               state_d    = LS_REQ;
            end else if (halt_req) begin
               state_d = HALT;
            end else begin
               state_d = IF_REQ;
            end
         end
         LS_REQ:  if (mem_req_ready) state_d = LS_WAIT;
         LS_WAIT: begin
            if (mem_resp_valid) begin
               rdata_d = mem_resp_data;
               state_d = WB;
            end
         end
         WB:      state_d = IF_REQ;
         HALT:    state_d = HALT;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase

      // Watchdog: progress (a state change) always wins over expiry
      if (state_d != state_q) begin
         wd_d = '0;
      end else if (wd_active) begin
         if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ERR;
            wd_d    = '0;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end

      if (retire) instret_d = instret_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wd_q       <= '0;
         inst_q     <= RESET_INST;
         rdata_q    <= '0;
         instret_q  <= '0;
         ls_addr_q  <= '0;
         ls_wdata_q <= '0;
         ls_wen_q   <= 1'b0;
         ls_op_q    <= '0;
      end else begin
         state_q    <= state_d;
         wd_q       <= wd_d;
         inst_q     <= inst_d;
         rdata_q    <= rdata_d;
         instret_q  <= instret_d;
         ls_addr_q  <= ls_addr_d;
         ls_wdata_q <= ls_wdata_d;
         ls_wen_q   <= ls_wen_d;
         ls_op_q    <= ls_op_d;
      end
   end

   // Port side: fetch address follows ifu_pc, which only moves after a commit
   assign mem_req_valid = (state_q == IF_REQ) || (state_q == LS_REQ);
   assign mem_req_addr  = (state_q == LS_REQ) ? ls_addr_q : ifu_pc;
   assign mem_req_wen   = (state_q == LS_REQ) && ls_wen_q;
   assign mem_req_op    = (state_q == LS_REQ) ? ls_op_q : FETCH_OP;
   assign mem_req_wdata = (state_q == LS_REQ) ? ls_wdata_q : 32'd0;

   assign inst      = inst_q;
   assign lsu_rdata = rdata_q;
   assign commit    = retire;
   assign halted    = (state_q == HALT);
   assign bus_err   = (state_q == ERR);
   assign instret   = instret_q;

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed bench for cpu_mem_sequencer: fetch, load, stalled store, halt, reset abort, watchdog.
module tb_cpu_mem_sequencer;

   localparam logic [31:0] STALE_WORD = 32'hBAD0_BAD0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ifu_pc;
   logic [31:0] inst;
   logic        lsu_req;
   logic        lsu_wen;
   logic [2:0]  lsu_op;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [31:0] lsu_rdata;
   logic        halt_req;
   logic        commit;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [2:0]  mem_req_op;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        halted;
   logic        bus_err;
   logic [31:0] instret;

   int          checks = 0;
   int          errors = 0;
   int          hs_cnt = 0;
   int          hs_mark;
   logic        resp_en;
   logic        stale;
   logic [31:0] resp_word;
   logic        seen_bad;

   always #5 clk = ~clk;

   cpu_mem_sequencer #(
      .TIMEOUT_CYCLES(8),
      .FETCH_OP      (3'b010),
      .RESET_INST    (32'h0000_0013)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_pc        (ifu_pc),
      .inst          (inst),
      .lsu_req       (lsu_req),
      .lsu_wen       (lsu_wen),
      .lsu_op        (lsu_op),
      .lsu_addr      (lsu_addr),
      .lsu_wdata     (lsu_wdata),
      .lsu_rdata     (lsu_rdata),
      .halt_req      (halt_req),
      .commit        (commit),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wen   (mem_req_wen),
      .mem_req_op    (mem_req_op),
      .mem_req_wdata (mem_req_wdata),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .halted        (halted),
      .bus_err       (bus_err),
      .instret       (instret)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock; the memory model answers one cycle after each accepted request
   task automatic tick();
      logic hs;
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      if (hs) hs_cnt++;
      @(posedge clk);
      #1;
      mem_resp_valid = (hs && resp_en) || stale;
      mem_resp_data  = stale ? STALE_WORD : resp_word;
   endtask

   initial begin
      rst = 1'b1; ifu_pc = 32'd0; lsu_req = 1'b0; lsu_wen = 1'b0; lsu_op = 3'd0;
      lsu_addr = 32'd0; lsu_wdata = 32'd0; halt_req = 1'b0; mem_req_ready = 1'b1;
      mem_resp_valid = 1'b0; mem_resp_data = 32'd0; resp_en = 1'b1; stale = 1'b0;
      resp_word = 32'd0;
      tick(); tick();

      check("rst_inst",    inst,              32'h0000_0013);
      check("rst_rdata",   lsu_rdata,         32'd0);
      check("rst_instret", instret,           32'd0);
      check("rst_commit",  32'(commit),        32'd0);
      check("rst_valid",   32'(mem_req_valid), 32'd0);
      check("rst_halted",  32'(halted),        32'd0);
      check("rst_buserr",  32'(bus_err),       32'd0);

      // Test 1: addi at pc 0, commit in the third cycle after IDLE
      rst = 1'b0; resp_word = 32'h0050_0093;
      tick();
      check("t1_valid",  32'(mem_req_valid), 32'd1);
      check("t1_addr",   mem_req_addr,       32'd0);
      check("t1_wen",    32'(mem_req_wen),   32'd0);
      check("t1_op",     32'(mem_req_op),    32'd2);
      check("t1_commit_c1", 32'(commit),     32'd0);
      tick();
      check("t1_valid_wait", 32'(mem_req_valid), 32'd0);
      check("t1_commit_c2",  32'(commit),        32'd0);
      tick();
      check("t1_inst",      inst,          32'h0050_0093);
      check("t1_commit_c3", 32'(commit),   32'd1);
      tick();
      check("t1_commit_off", 32'(commit),  32'd0);
      check("t1_instret",    instret,      32'd1);

      // Test 2: lw from 0x80000100
      ifu_pc = 32'd4; resp_word = 32'h0000_2083;
      lsu_addr = 32'h8000_0100; lsu_op = 3'b010; lsu_wen = 1'b0; lsu_wdata = 32'h1111_1111;
      #1;
      check("t2_fetch_addr", mem_req_addr, 32'd4);
      tick();
      tick();
      lsu_req = 1'b1; resp_word = 32'hDEAD_BEEF;
      #1;
      check("t2_inst",      inst,        32'h0000_2083);
      check("t2_ex_commit", 32'(commit), 32'd0);
      tick();
      lsu_req = 1'b0;
      check("t2_ls_valid", 32'(mem_req_valid), 32'd1);
      check("t2_ls_addr",  mem_req_addr,       32'h8000_0100);
      check("t2_ls_wen",   32'(mem_req_wen),   32'd0);
      check("t2_ls_op",    32'(mem_req_op),    32'd2);
      tick();
      tick();
      check("t2_rdata",     lsu_rdata,   32'hDEAD_BEEF);
      check("t2_wb_commit", 32'(commit), 32'd1);
      tick();
      check("t2_instret", instret,     32'd2);
      check("t2_hs_cnt",  32'(hs_cnt), 32'd3);

      // Test 3: sw with ready held low for 5 cycles
      ifu_pc = 32'd8; resp_word = 32'h0011_2423;
      tick();
      tick();
      lsu_req = 1'b1; lsu_wen = 1'b1; lsu_op = 3'b010;
      lsu_addr = 32'h8000_0200; lsu_wdata = 32'hCAFE_F00D;
      mem_req_ready = 1'b0; resp_word = 32'h5A5A_5A5A;
      tick();
      lsu_req = 1'b0;
      hs_mark = hs_cnt;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", 32'(mem_req_valid), 32'd1);
         check("t3_hold_addr",  mem_req_addr,       32'h8000_0200);
         check("t3_hold_wdata", mem_req_wdata,      32'hCAFE_F00D);
         check("t3_hold_wen",   32'(mem_req_wen),   32'd1);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      check("t3_one_hs",  32'(hs_cnt - hs_mark), 32'd1);
      check("t3_no_commit_wait", 32'(commit),    32'd0);
      tick();
      check("t3_commit", 32'(commit), 32'd1);
      check("t3_rdata",  lsu_rdata,   32'h5A5A_5A5A);
      tick();
      check("t3_instret", instret, 32'd3);

      // Test 5: ebreak halts the sequencer
      ifu_pc = 32'd12; resp_word = 32'h0010_0073;
      tick();
      tick();
      halt_req = 1'b1;
      #1;
      check("t5_commit", 32'(commit), 32'd1);
      tick();
      halt_req = 1'b0;
      check("t5_halted",  32'(halted), 32'd1);
      check("t5_instret", instret,     32'd4);
      hs_mark = hs_cnt; seen_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen_bad = seen_bad | mem_req_valid | commit | ~halted;
         tick();
      end
      check("t5_quiet",          32'(seen_bad),          32'd0);
      check("t5_instret_frozen", instret,                32'd4);
      check("t5_no_hs",          32'(hs_cnt - hs_mark),  32'd0);

      // Test 6: reset while in LS_WAIT, stale response afterwards
      rst = 1'b1;
      tick();
      rst = 1'b0; ifu_pc = 32'h100; resp_word = 32'h0000_A103;
      tick(); tick(); tick();
      lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0300; resp_en = 1'b0;
      tick();
      lsu_req = 1'b0;
      tick();
      check("t6_in_lswait_valid", 32'(mem_req_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0; stale = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = STALE_WORD;
      check("t6_rst_inst",    inst,             32'h0000_0013);
      check("t6_rst_instret", instret,          32'd0);
      check("t6_rst_halted",  32'(halted),      32'd0);
      check("t6_rst_rdata",   lsu_rdata,        32'd0);
      tick();
      check("t6_fetch_valid", 32'(mem_req_valid), 32'd1);
      check("t6_fetch_addr",  mem_req_addr,       32'h100);
      check("t6_inst_ifreq",  inst,               32'h0000_0013);
      stale = 1'b0; resp_en = 1'b1; resp_word = 32'h0030_0193;
      tick();
      check("t6_inst_ifwait", inst, 32'h0000_0013);
      tick();
      check("t6_inst_new",   inst,        32'h0030_0193);
      check("t6_rdata_kept", lsu_rdata,   32'd0);
      check("t6_commit",     32'(commit), 32'd1);

      // Test 4: watchdog expiry in IF_WAIT with TIMEOUT_CYCLES=8
      ifu_pc = 32'h104; resp_en = 1'b0;
      tick();
      check("t4_instret", instret, 32'd1);
      tick();
      hs_mark = hs_cnt;
      for (int i = 0; i < 8; i++) begin
         check("t4_not_yet", 32'(bus_err), 32'd0);
         tick();
      end
      check("t4_bus_err", 32'(bus_err), 32'd1);
      seen_bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         seen_bad = seen_bad | mem_req_valid | commit | ~bus_err;
         tick();
      end
      check("t4_quiet",   32'(seen_bad),         32'd0);
      check("t4_no_hs",   32'(hs_cnt - hs_mark), 32'd0);
      check("t4_instret_frozen", instret,        32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
